// File: rtl/ex_muldiv_pkg.sv
// Shared op codes, FSM state type and op-classification helpers for the
// RV32M multiply/divide unit.
package ex_muldiv_pkg;

    localparam int OP_W  = 8;
    localparam int REG_W = 5;

    localparam logic [OP_W-1:0] OP_NOP    = 8'h00;
    localparam logic [OP_W-1:0] OP_ADD    = 8'h01;
    localparam logic [OP_W-1:0] OP_MUL    = 8'h20;
    localparam logic [OP_W-1:0] OP_MULH   = 8'h21;
    localparam logic [OP_W-1:0] OP_MULHSU = 8'h22;
    localparam logic [OP_W-1:0] OP_MULHU  = 8'h23;
    localparam logic [OP_W-1:0] OP_DIV    = 8'h24;
    localparam logic [OP_W-1:0] OP_DIVU   = 8'h25;
    localparam logic [OP_W-1:0] OP_REM    = 8'h26;
    localparam logic [OP_W-1:0] OP_REMU   = 8'h27;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    function automatic logic is_md_op(input logic [OP_W-1:0] op);
        return (op >= OP_MUL) && (op <= OP_REMU);
    endfunction

    function automatic logic is_div_op(input logic [OP_W-1:0] op);
        return (op >= OP_DIV) && (op <= OP_REMU);
    endfunction

    function automatic logic is_rem_op(input logic [OP_W-1:0] op);
        return (op == OP_REM) || (op == OP_REMU);
    endfunction

    // rs1 is signed for everything except the fully unsigned forms
    function automatic logic rs1_signed(input logic [OP_W-1:0] op);
        return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
               (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic rs2_signed(input logic [OP_W-1:0] op);
        return (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// Shared radix-2 datapath: shift-add multiply or restoring divide on
// unsigned magnitudes, one step per enabled cycle.
module muldiv_iter_core #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              step,
    input  logic              is_div,
    input  logic [DATA_W-1:0] a_in,
    input  logic [DATA_W-1:0] b_in,
    output logic [DATA_W-1:0] step_hi,
    output logic [DATA_W-1:0] step_lo
);

    logic [DATA_W-1:0] hi_q, hi_d;
    logic [DATA_W-1:0] lo_q, lo_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [DATA_W:0]   mul_sum;
    logic [DATA_W:0]   div_sh;
    logic [DATA_W:0]   div_diff;

    // hi holds the upper product / partial remainder, lo the multiplier / quotient
    always_comb begin
        mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : {(DATA_W+1){1'b0}});
        div_sh   = {hi_q, lo_q[DATA_W-1]};
        div_diff = div_sh - {1'b0, b_q};
        if (is_div) begin
            if (!div_diff[DATA_W]) begin
                step_hi = div_diff[DATA_W-1:0];
                step_lo = {lo_q[DATA_W-2:0], 1'b1};
            end else begin
                step_hi = div_sh[DATA_W-1:0];
                step_lo = {lo_q[DATA_W-2:0], 1'b0};
            end
        end else begin
            step_hi = mul_sum[DATA_W:1];
            step_lo = {mul_sum[0], lo_q[DATA_W-1:1]};
        end

        hi_d = hi_q;
        lo_d = lo_q;
        b_d  = b_q;
        if (load) begin
            hi_d = '0;
            lo_d = a_in;
            b_d  = b_in;
        end else if (step) begin
            hi_d = step_hi;
            lo_d = step_lo;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_q <= '0;
            lo_q <= '0;
            b_q  <= '0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
            b_q  <= b_d;
        end
    end

endmodule

// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide unit in EX. Holds id_ex via md_stall while
// the shared core runs DATA_W steps; sign handling and special cases live here.
import ex_muldiv_pkg::*;

module ex_muldiv #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              ex_hold,
    input  logic              jump_or_not,
    input  logic              id_ex_rdy,
    input  logic [OP_W-1:0]   ex_op,
    input  logic [DATA_W-1:0] ex_reg1,
    input  logic [DATA_W-1:0] ex_reg2,
    input  logic [REG_W-1:0]  ex_rd,
    output logic              md_stall,
    output logic              md_done,
    output logic [DATA_W-1:0] md_result,
    output logic [REG_W-1:0]  md_rd
);

    localparam logic [DATA_W-1:0] ZERO_WORD = '0;
    localparam logic [DATA_W-1:0] ALL_ONES  = '1;
    localparam logic [DATA_W-1:0] INT_MIN   = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [CNT_W-1:0]  LAST_STEP = CNT_W'(DATA_W - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic              neg_q, neg_d;
    logic              s1_q, s1_d;
    logic [REG_W-1:0]  rd_q, rd_d;
    logic              md_done_q, md_done_d;
    logic [DATA_W-1:0] md_result_q, md_result_d;
    logic [REG_W-1:0]  md_rd_q, md_rd_d;

    logic              en, flush, start;
    logic              s1, s2, div_zero, div_ovf;
    logic [DATA_W-1:0] mag1, mag2, special_res, calc_res;
    logic              core_load, core_step;
    logic [DATA_W-1:0] step_hi, step_lo;
    logic [2*DATA_W-1:0] prod, prod_fix;

    assign en    = rdy & ~ex_hold;
    assign flush = rdy & jump_or_not;
    assign start = id_ex_rdy & is_md_op(ex_op);

    assign md_stall  = ((state_q == S_IDLE) & start) | (state_q == S_CALC);
    assign md_done   = md_done_q;
    assign md_result = md_result_q;
    assign md_rd     = md_rd_q;

    // Operand magnitudes and the cases resolved without iterating
    always_comb begin
        s1       = rs1_signed(ex_op) & ex_reg1[DATA_W-1];
        s2       = rs2_signed(ex_op) & ex_reg2[DATA_W-1];
        mag1     = s1 ? -ex_reg1 : ex_reg1;
        mag2     = s2 ? -ex_reg2 : ex_reg2;
        div_zero = is_div_op(ex_op) & (ex_reg2 == ZERO_WORD);
        div_ovf  = is_div_op(ex_op) & rs2_signed(ex_op) &
                   (ex_reg1 == INT_MIN) & (ex_reg2 == ALL_ONES);
        if (div_zero)
            special_res = is_rem_op(ex_op) ? ex_reg1 : ALL_ONES;
        else
            special_res = is_rem_op(ex_op) ? ZERO_WORD : INT_MIN;
    end

    // Sign-corrected result taken from the core's final step values
    always_comb begin
        prod     = {step_hi, step_lo};
        prod_fix = neg_q ? -prod : prod;
        if (!is_div_op(op_q))
            calc_res = (op_q == OP_MUL) ? prod_fix[DATA_W-1:0] : prod_fix[2*DATA_W-1:DATA_W];
        else if (is_rem_op(op_q))
            calc_res = s1_q ? -step_hi : step_hi;
        else
            calc_res = neg_q ? -step_lo : step_lo;
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        neg_d       = neg_q;
        s1_d        = s1_q;
        rd_d        = rd_q;
        md_done_d   = md_done_q;
        md_result_d = md_result_q;
        md_rd_d     = md_rd_q;
        core_load   = 1'b0;
        core_step   = 1'b0;
        if (flush) begin
            state_d   = S_IDLE;
            md_done_d = 1'b0;
        end else if (en) begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        op_d  = ex_op;
                        neg_d = s1 ^ s2;
                        s1_d  = s1;
                        rd_d  = ex_rd;
                        cnt_d = '0;
                        if (div_zero | div_ovf) begin
                            state_d     = S_DONE;
                            md_done_d   = 1'b1;
                            md_result_d = special_res;
                            md_rd_d     = ex_rd;
                        end else begin
                            state_d   = S_CALC;
                            core_load = 1'b1;
                        end
                    end
                end
                S_CALC: begin
                    core_step = 1'b1;
                    cnt_d     = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_STEP) begin
                        state_d     = S_DONE;
                        md_done_d   = 1'b1;
                        md_result_d = calc_res;
                        md_rd_d     = rd_q;
                    end
                end
                S_DONE: begin
                    state_d   = S_IDLE;
                    md_done_d = 1'b0;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            op_q        <= '0;
            neg_q       <= 1'b0;
            s1_q        <= 1'b0;
            rd_q        <= '0;
            md_done_q   <= 1'b0;
            md_result_q <= '0;
            md_rd_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            neg_q       <= neg_d;
            s1_q        <= s1_d;
            rd_q        <= rd_d;
            md_done_q   <= md_done_d;
            md_result_q <= md_result_d;
            md_rd_q     <= md_rd_d;
        end
    end

    muldiv_iter_core #(.DATA_W(DATA_W)) u_core (
        .clk     (clk),
        .rst     (rst),
        .load    (core_load),
        .step    (core_step),
        .is_div  (is_div_op(op_q)),
        .a_in    (mag1),
        .b_in    (mag2),
        .step_hi (step_hi),
        .step_lo (step_lo)
    );

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv: directed vector table, stall/flush/reset
// sequences and randomized ops against a plain-arithmetic reference model.
module tb_ex_muldiv;
    import ex_muldiv_pkg::*;

    localparam int W = 32;

    logic             clk = 1'b0;
    logic             rst, rdy, ex_hold, jump_or_not, id_ex_rdy;
    logic [OP_W-1:0]  ex_op;
    logic [W-1:0]     ex_reg1, ex_reg2;
    logic [REG_W-1:0] ex_rd;
    logic             md_stall, md_done;
    logic [W-1:0]     md_result;
    logic [REG_W-1:0] md_rd;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [OP_W-1:0] op;
        logic [W-1:0]    a;
        logic [W-1:0]    b;
        logic [W-1:0]    exp;
        int              lat;
    } vec_t;

    vec_t tbl[12];

    always #5 clk = ~clk;

    ex_muldiv #(.DATA_W(W), .CNT_W(6)) dut (
        .clk         (clk),
        .rst         (rst),
        .rdy         (rdy),
        .ex_hold     (ex_hold),
        .jump_or_not (jump_or_not),
        .id_ex_rdy   (id_ex_rdy),
        .ex_op       (ex_op),
        .ex_reg1     (ex_reg1),
        .ex_reg2     (ex_reg2),
        .ex_rd       (ex_rd),
        .md_stall    (md_stall),
        .md_done     (md_done),
        .md_result   (md_result),
        .md_rd       (md_rd)
    );

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic adv();
        @(posedge clk);
        @(negedge clk);
    endtask

    // RV32M semantics from plain 64-bit / SV integer arithmetic
    function automatic logic [W-1:0] ref_result(input logic [OP_W-1:0] op,
                                                input logic [W-1:0] a, input logic [W-1:0] b);
        logic [63:0] p;
        longint sa, sb;
        longint unsigned ua, ub;
        int ia, ib;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        ia = $signed(a);
        ib = $signed(b);
        case (op)
            OP_MUL:    begin p = sa * sb; return p[31:0];  end
            OP_MULH:   begin p = sa * sb; return p[63:32]; end
            OP_MULHSU: begin p = sa * longint'(ub); return p[63:32]; end
            OP_MULHU:  begin p = ua * ub; return p[63:32]; end
            OP_DIV: begin
                if (b == 0) return 32'hFFFFFFFF;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
                return ia / ib;
            end
            OP_REM: begin
                if (b == 0) return a;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
                return ia % ib;
            end
            OP_DIVU: return (b == 0) ? 32'hFFFFFFFF : a / b;
            OP_REMU: return (b == 0) ? a : a % b;
            default: return 32'h0;
        endcase
    endfunction

    function automatic int ref_latency(input logic [OP_W-1:0] op,
                                       input logic [W-1:0] a, input logic [W-1:0] b);
        if (op >= OP_DIV && op <= OP_REMU && b == 0) return 1;
        if ((op == OP_DIV || op == OP_REM) && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
        return 33;
    endfunction

    // Presents one op in cycle T and follows it until md_done; cycle T+k is
    // observed at the negedge after k rising edges.
    task automatic run_op(input string nm, input logic [OP_W-1:0] op,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] exp, input int exp_lat,
                          input int frz_at, input int frz_len, input bit use_hold);
        logic [REG_W-1:0] rd;
        int  lat;
        bit  stall_ok;
        rd        = REG_W'($urandom_range(1, 31));
        ex_op     = op;
        ex_reg1   = a;
        ex_reg2   = b;
        ex_rd     = rd;
        id_ex_rdy = 1'b1;
        #1;
        stall_ok = (md_stall === 1'b1);
        lat = -1;
        for (int k = 1; k <= 80; k++) begin
            adv();
            if (md_done === 1'b1) begin
                lat = k;
                if (md_stall !== 1'b0) stall_ok = 1'b0;
                break;
            end
            if (md_stall !== 1'b1) stall_ok = 1'b0;
            if (frz_len > 0 && k == frz_at) begin
                if (use_hold) ex_hold = 1'b1; else rdy = 1'b0;
            end
            if (frz_len > 0 && k == frz_at + frz_len) begin
                ex_hold = 1'b0;
                rdy     = 1'b1;
            end
        end
        id_ex_rdy = 1'b0;
        ex_op     = OP_ADD;
        ex_hold   = 1'b0;
        rdy       = 1'b1;
        check({nm, " latency"}, 64'(lat), 64'(exp_lat));
        check({nm, " result"}, 64'(md_result), 64'(exp));
        check({nm, " rd"}, 64'(md_rd), 64'(rd));
        check({nm, " stall"}, 64'(stall_ok), 64'd1);
        if (lat > 0) begin
            adv();
            check({nm, " done_single"}, 64'(md_done), 64'd0);
            check({nm, " hold"}, 64'(md_result), 64'(exp));
        end
    endtask

    initial begin
        logic [W-1:0] prev, a, b;
        logic [OP_W-1:0] op;
        bit done_seen;

        tbl[0]  = '{OP_MUL,    32'd7,          32'hFFFFFFFD, 32'hFFFFFFEB, 33};
        tbl[1]  = '{OP_MULHU,  32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFE, 33};
        tbl[2]  = '{OP_MULH,   32'hFFFFFFFF,   32'hFFFFFFFF, 32'h00000000, 33};
        tbl[3]  = '{OP_DIV,    32'h80000000,   32'hFFFFFFFF, 32'h80000000, 1};
        tbl[4]  = '{OP_REM,    32'd5,          32'd0,        32'd5,        1};
        tbl[5]  = '{OP_DIV,    32'hFFFFFFF9,   32'd2,        32'hFFFFFFFD, 33};
        tbl[6]  = '{OP_REM,    32'hFFFFFFF9,   32'd2,        32'hFFFFFFFF, 33};
        tbl[7]  = '{OP_DIVU,   32'd5,          32'd0,        32'hFFFFFFFF, 1};
        tbl[8]  = '{OP_REM,    32'h80000000,   32'hFFFFFFFF, 32'h00000000, 1};
        tbl[9]  = '{OP_MULHSU, 32'hFFFFFFFF,   32'd2,        32'hFFFFFFFF, 33};
        tbl[10] = '{OP_DIVU,   32'd100,        32'd7,        32'd14,       33};
        tbl[11] = '{OP_REMU,   32'd100,        32'd7,        32'd2,        33};

        rst = 1'b1; rdy = 1'b1; ex_hold = 1'b0; jump_or_not = 1'b0; id_ex_rdy = 1'b0;
        ex_op = OP_NOP; ex_reg1 = '0; ex_reg2 = '0; ex_rd = '0;
        repeat (2) @(negedge clk);
        check("reset md_done", 64'(md_done), 64'd0);
        check("reset md_result", 64'(md_result), 64'd0);
        check("reset md_rd", 64'(md_rd), 64'd0);
        check("reset md_stall", 64'(md_stall), 64'd0);
        rst = 1'b0;
        adv();

        // Non-M op must not stall or complete
        ex_op = OP_ADD; ex_reg1 = 32'd3; ex_reg2 = 32'd4; ex_rd = 5'd9; id_ex_rdy = 1'b1;
        #1;
        check("nonm stall", 64'(md_stall), 64'd0);
        done_seen = 1'b0;
        for (int k = 0; k < 4; k++) begin
            adv();
            done_seen |= md_done;
        end
        check("nonm done", 64'(done_seen), 64'd0);
        id_ex_rdy = 1'b0;
        adv();

        for (int i = 0; i < 12; i++)
            run_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b,
                   tbl[i].exp, tbl[i].lat, 0, 0, 1'b0);

        run_op("freeze_rdy", OP_MUL, 32'd12345, 32'd6789,
               ref_result(OP_MUL, 32'd12345, 32'd6789), 38, 10, 5, 1'b0);
        run_op("freeze_hold", OP_DIV, 32'hFFFF0001, 32'd77,
               ref_result(OP_DIV, 32'hFFFF0001, 32'd77), 36, 20, 3, 1'b1);

        // Flush in cycle T+10 abandons the op
        prev = md_result;
        ex_op = OP_DIVU; ex_reg1 = 32'd100; ex_reg2 = 32'd7; ex_rd = 5'd3; id_ex_rdy = 1'b1;
        done_seen = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            adv();
            done_seen |= md_done;
        end
        jump_or_not = 1'b1;
        adv();
        jump_or_not = 1'b0;
        id_ex_rdy   = 1'b0;
        ex_op       = OP_ADD;
        #1;
        check("flush stall", 64'(md_stall), 64'd0);
        for (int k = 0; k < 40; k++) begin
            adv();
            done_seen |= md_done;
        end
        check("flush no_done", 64'(done_seen), 64'd0);
        check("flush result_held", 64'(md_result), 64'(prev));

        // Async reset mid-CALC clears outputs without a clock edge
        ex_op = OP_MULHU; ex_reg1 = 32'hFFFFFFFF; ex_reg2 = 32'hFFFFFFFF; ex_rd = 5'd7;
        id_ex_rdy = 1'b1;
        for (int k = 1; k <= 20; k++) adv();
        #2;
        rst = 1'b1;
        id_ex_rdy = 1'b0;
        ex_op = OP_ADD;
        #1;
        check("arst md_done", 64'(md_done), 64'd0);
        check("arst md_result", 64'(md_result), 64'd0);
        check("arst md_rd", 64'(md_rd), 64'd0);
        check("arst md_stall", 64'(md_stall), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        adv();
        run_op("after_rst", OP_MUL, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 33, 0, 0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            op = OP_W'(OP_MUL + OP_W'($urandom_range(0, 7)));
            case ($urandom_range(0, 6))
                0: a = 32'h0;
                1: a = 32'hFFFFFFFF;
                2: a = 32'h80000000;
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 6))
                0: b = 32'h0;
                1: b = 32'hFFFFFFFF;
                2: b = 32'd1;
                default: b = $urandom;
            endcase
            run_op($sformatf("rnd%0d op%0h a%0h b%0h", i, op, a, b), op, a, b,
                   ref_result(op, a, b), ref_latency(op, a, b), 0, 0, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
